// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays short built-in tunes one beat at a time and drives the
// tone word and amplifier enable for the buzzer/PWM driver. It supports
// start/stop, looping, an octave shift, retriggering, and a done pulse.
module sfx_sequencer #(
  parameter int BEAT_DIV    = 12500000,
  parameter int NUM_EFFECTS = 4,
  parameter int MAX_BEATS   = 8,
  parameter int TONE_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        effect_sel,
  input  logic [1:0]        octave,
  input  logic              loop,
  input  logic              stop,
  output logic [TONE_W-1:0] tone,
  output logic              amp_en,
  output logic [7:0]        beatnum,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W    = $clog2(BEAT_DIV);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(BEAT_DIV - 1);
  localparam logic [2:0]      NumEff   = 3'(NUM_EFFECTS);
  localparam logic [7:0]      MaxBeats = 8'(MAX_BEATS);

  typedef enum logic {
    IDLE,
    PLAY
  } state_e;

  state_e             state_q, stateD;
  logic [1:0]         sel_q, selD;
  logic [1:0]         oct_q, octD;
  logic [7:0]         beat_q, beatD;
  logic [CNT_W-1:0]   cnt_q, cntD;
  logic [TONE_W-1:0]  tone_q, toneD;
  logic               amp_q, ampD;
  logic               done_q, doneD;

  logic               startOk;
  logic [7:0]         lenEff;
  logic [7:0]         lenM1;
  logic [10:0]        romVal;

  // Tune ROM in Hz. A value of 0 marks a rest beat.
  function automatic logic [10:0] romTone(input logic [1:0] s, input logic [7:0] b);
    romTone = '0;
    case (s)
      2'd0: case (b)
              8'd0:    romTone = 11'd523;
              8'd1:    romTone = 11'd1046;
              default: romTone = '0;
            endcase
      2'd1: case (b)
              8'd0:    romTone = 11'd880;
              8'd2:    romTone = 11'd880;
              default: romTone = '0;
            endcase
      2'd2: case (b)
              8'd0:    romTone = 11'd392;
              8'd1:    romTone = 11'd349;
              8'd2:    romTone = 11'd330;
              8'd3:    romTone = 11'd262;
              default: romTone = '0;
            endcase
      default: case (b)
              8'd0:    romTone = 11'd523;
              8'd1:    romTone = 11'd659;
              8'd2:    romTone = 11'd784;
              8'd3:    romTone = 11'd1046;
              8'd5:    romTone = 11'd1046;
              default: romTone = '0;
            endcase
    endcase
  endfunction

  // Number of beats in each tune.
  function automatic logic [7:0] romLen(input logic [1:0] s);
    case (s)
      2'd0:    romLen = 8'd2;
      2'd1:    romLen = 8'd3;
      2'd2:    romLen = 8'd4;
      default: romLen = 8'd6;
    endcase
  endfunction

  // A start counts only when stop is low and the selected tune exists.
  // A tune never plays more than MAX_BEATS beats.
  always_comb begin
    startOk = start && !stop && ({1'b0, effect_sel} < NumEff);
    lenEff  = (romLen(sel_q) > MaxBeats) ? MaxBeats : romLen(sel_q);
    lenM1   = lenEff - 8'd1;
  end

  // Sequencer control. Stop has the highest priority, then a legal start
  // (which also covers retrigger and a start on the last beat), then the
  // normal beat stepping.
  always_comb begin
    stateD = state_q;
    selD   = sel_q;
    octD   = oct_q;
    beatD  = beat_q;
    cntD   = cnt_q;
    doneD  = 1'b0;
    if (stop) begin
      stateD = IDLE;
      beatD  = '0;
      cntD   = '0;
    end else if (startOk) begin
      stateD = PLAY;
      selD   = effect_sel;
      octD   = octave;
      beatD  = '0;
      cntD   = '0;
    end else if (state_q == PLAY) begin
      if (cnt_q == CntLast) begin
        cntD = '0;
        if (beat_q < lenM1) begin
          beatD = beat_q + 8'd1;
        end else if (loop) begin
          beatD = '0;
        end else begin
          stateD = IDLE;
          beatD  = '0;
          doneD  = 1'b1;
        end
      end else begin
        cntD = cnt_q + 1'b1;
      end
    end
  end

  // Compute the next tone and amp enable from the next state, so that both
  // are registered and change on the same edge as beatnum.
  always_comb begin
    romVal = romTone(selD, beatD);
    toneD  = '0;
    if (stateD == PLAY) begin
      toneD = TONE_W'(romVal) << octD;
    end
    ampD = (stateD == PLAY) && (toneD != '0);
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      oct_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      tone_q  <= '0;
      amp_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= stateD;
      sel_q   <= selD;
      oct_q   <= octD;
      beat_q  <= beatD;
      cnt_q   <= cntD;
      tone_q  <= toneD;
      amp_q   <= ampD;
      done_q  <= doneD;
    end
  end

  assign tone    = tone_q;
  assign amp_en  = amp_q;
  assign beatnum = beat_q;
  assign busy    = (state_q == PLAY);
  assign done    = done_q;

endmodule
